fir_feeder: RTL and testbench



---
 rtl/fir_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_fir_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_feeder.sv
// fir_feeder
//
// Host-side transmitter for the W4823 FIR datapath, clk_fast domain.
// After reset it loads NCOEF coefficients from an upstream valid/ready
// stream into the FIR coefficient write port, then feeds one FP16 sample
// per FIR frame, locked to the frame period. Load timeouts and sample
// underruns are flagged with sticky outputs.
//
// Optional feature macro: FEEDER_UNDERRUN_HOLD_EN
//   defined   : on underrun, o_din keeps the previous sample
//   undefined : on underrun, o_din is driven to 16'h0000
//
// Ports:
//   clk_fast        in   fast clock
//   rst_n           in   asynchronous active-low reset
//   i_coef_data     in   [16:0] FP16i coefficient from upstream
//   i_coef_valid    in   upstream coefficient valid
//   o_coef_ready    out  coefficient accepted on valid & ready
//   i_smp_data      in   [15:0] FP16 sample from upstream
//   i_smp_valid     in   upstream sample valid
//   o_smp_ready     out  sample accepted on valid & ready
//   o_cin           out  [16:0] coefficient data to FIR
//   o_caddr         out  [5:0] coefficient address to FIR
//   o_cload         out  coefficient write strobe (FIR writes on rising edge)
//   o_din           out  [15:0] sample to FIR, held for a whole frame
//   o_valid_in      out  one-cycle pulse at frame phase 0
//   o_load_done     out  coefficient load finished (or abandoned by timeout)
//   o_load_timeout  out  sticky: load window expired before load finished
//   o_underrun      out  sticky: no sample available at a frame boundary
module fir_feeder #(
  parameter int FRAME_LEN   = 257,
  parameter int LOAD_WINDOW = 240,
  parameter int FIRST_FRAME = 256,
  parameter int NCOEF       = 64
) (
  input  logic        clk_fast,
  input  logic        rst_n,
  input  logic [16:0] i_coef_data,
  input  logic        i_coef_valid,
  output logic        o_coef_ready,
  input  logic [15:0] i_smp_data,
  input  logic        i_smp_valid,
  output logic        o_smp_ready,
  output logic [16:0] o_cin,
  output logic [5:0]  o_caddr,
  output logic        o_cload,
  output logic [15:0] o_din,
  output logic        o_valid_in,
  output logic        o_load_done,
  output logic        o_load_timeout,
  output logic        o_underrun
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam logic [FCW-1:0] FRAME_LAST   = FCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FRAME_PHASE0 = FCW'(FIRST_FRAME);
  localparam logic [8:0]     WIN_END      = 9'(LOAD_WINDOW);
  localparam logic [5:0]     LAST_ADDR    = 6'(NCOEF - 1);

  typedef enum logic [1:0] {
    LOAD_SETUP,
    LOAD_STROBE,
    LOAD_HOLD,
    STREAM
  } state_t;

  state_t r_state, w_fsmNext, w_stateNext;

  logic [16:0]    r_cin;
  logic [5:0]     r_caddr;
  logic           r_cload;
  logic [15:0]    r_din;
  logic           r_validIn;
  logic           r_coefReady;
  logic           r_smpReady;
  logic           r_loadDone;
  logic           r_loadTimeout;
  logic           r_underrun;
  logic [15:0]    r_smpBuf;
  logic           r_smpFull;
  logic [8:0]     r_winCnt;
  logic [FCW-1:0] r_frameCnt;

  logic           w_coefAcc;
  logic           w_smpAcc;
  logic           w_timeoutHit;
  logic           w_phase0Next;
  logic [8:0]     w_winNext;
  logic [FCW-1:0] w_frameNext;
  logic [15:0]    w_smpBufNext;
  logic           w_smpFullNext;
  logic [15:0]    w_dinNext;
  logic           w_underrunSet;

  // State register of the load/stream sequencer.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD_SETUP;
    else        r_state <= w_stateNext;
  end

  // Next-state logic. The window counter overrides the sequencer: once the
  // window closes without the load being complete, the feeder jumps to
  // STREAM and the rest of the coefficient memory is left undefined.
  always_comb begin
    w_coefAcc = i_coef_valid & r_coefReady;
    w_fsmNext = r_state;
    case (r_state)
      LOAD_SETUP:  if (w_coefAcc) w_fsmNext = LOAD_STROBE;
      LOAD_STROBE: w_fsmNext = LOAD_HOLD;
      LOAD_HOLD:   w_fsmNext = (r_caddr == LAST_ADDR) ? STREAM : LOAD_SETUP;
      default:     w_fsmNext = STREAM;
    endcase
    w_winNext    = (r_winCnt == WIN_END) ? r_winCnt : r_winCnt + 9'd1;
    w_timeoutHit = (w_winNext == WIN_END) && (w_fsmNext != STREAM);
    w_stateNext  = w_timeoutHit ? STREAM : w_fsmNext;
  end

  // Frame phase and sample buffer. The counter only ever wraps at
  // FRAME_LEN-1, so with FIRST_FRAME < FRAME_LEN the value FIRST_FRAME marks
  // phase 0 both for the first frame and for every later one.
  // An accept coinciding with an empty-buffer phase 0 is not bypassed: the
  // sample is stored for the next frame and this frame is an underrun.
  always_comb begin
    w_frameNext   = (r_frameCnt == FRAME_LAST) ? '0 : r_frameCnt + 1'b1;
    w_phase0Next  = (w_frameNext == FRAME_PHASE0);
    w_smpAcc      = i_smp_valid & r_smpReady;
    w_smpBufNext  = r_smpBuf;
    w_smpFullNext = r_smpFull;
    w_dinNext     = r_din;
    w_underrunSet = 1'b0;
    if (w_smpAcc) begin
      w_smpBufNext  = i_smp_data;
      w_smpFullNext = 1'b1;
    end
    if (w_phase0Next) begin
      if (r_state != STREAM) begin
        w_dinNext = 16'h0000;
      end else if (r_smpFull) begin
        w_dinNext     = r_smpBuf;
        w_smpFullNext = 1'b0;
      end else begin
        w_underrunSet = 1'b1;
`ifdef FEEDER_UNDERRUN_HOLD_EN
        w_dinNext = r_din;
`else
        w_dinNext = 16'h0000;
`endif
      end
    end
  end

  // Registered datapath and outputs. The write strobe is issued one cycle
  // after cin is captured, so cin/caddr are settled a full cycle before the
  // rising edge of cload and stay put for the cycle after it. A strobe that
  // would land in the first cycle after the window closes is dropped.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_cin         <= '0;
      r_caddr       <= '0;
      r_cload       <= 1'b0;
      r_din         <= '0;
      r_validIn     <= 1'b0;
      r_coefReady   <= 1'b1;
      r_smpReady    <= 1'b0;
      r_loadDone    <= 1'b0;
      r_loadTimeout <= 1'b0;
      r_underrun    <= 1'b0;
      r_smpBuf      <= '0;
      r_smpFull     <= 1'b0;
      r_winCnt      <= '0;
      r_frameCnt    <= '0;
    end else begin
      if (w_coefAcc) r_cin <= i_coef_data;
      if (r_state == LOAD_HOLD) r_caddr <= r_caddr + 6'd1;
      r_cload       <= (r_state == LOAD_STROBE) && !w_timeoutHit;
      r_coefReady   <= (w_stateNext == LOAD_SETUP);
      r_loadDone    <= (w_stateNext == STREAM);
      r_loadTimeout <= r_loadTimeout | w_timeoutHit;
      r_smpReady    <= (w_stateNext == STREAM) && !w_smpFullNext;
      r_underrun    <= r_underrun | w_underrunSet;
      r_validIn     <= w_phase0Next;
      r_din         <= w_dinNext;
      r_smpBuf      <= w_smpBufNext;
      r_smpFull     <= w_smpFullNext;
      r_winCnt      <= w_winNext;
      r_frameCnt    <= w_frameNext;
    end
  end

  assign o_cin          = r_cin;
  assign o_caddr        = r_caddr;
  assign o_cload        = r_cload;
  assign o_din          = r_din;
  assign o_valid_in     = r_validIn;
  assign o_coef_ready   = r_coefReady;
  assign o_smp_ready    = r_smpReady;
  assign o_load_done    = r_loadDone;
  assign o_load_timeout = r_loadTimeout;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_fir_feeder.sv
// Testbench for fir_feeder: directed scenarios with randomized upstream
// traffic, compared cycle by cycle against a transaction-level model of the
// coefficient load, window timeout, frame cadence and one-entry sample buffer.
module tb_fir_feeder;
  localparam int FRAME_LEN   = 257;
  localparam int LOAD_WINDOW = 240;
  localparam int FIRST_FRAME = 256;
  localparam int NCOEF       = 64;

  logic        clk_fast = 1'b0;
  logic        rst_n = 1'b1;
  logic [16:0] i_coef_data = '0;
  logic        i_coef_valid = 1'b0;
  logic        o_coef_ready;
  logic [15:0] i_smp_data = '0;
  logic        i_smp_valid = 1'b0;
  logic        o_smp_ready;
  logic [16:0] o_cin;
  logic [5:0]  o_caddr;
  logic        o_cload;
  logic [15:0] o_din;
  logic        o_valid_in;
  logic        o_load_done;
  logic        o_load_timeout;
  logic        o_underrun;

  fir_feeder #(
    .FRAME_LEN(FRAME_LEN), .LOAD_WINDOW(LOAD_WINDOW),
    .FIRST_FRAME(FIRST_FRAME), .NCOEF(NCOEF)
  ) dut (
    .clk_fast(clk_fast), .rst_n(rst_n),
    .i_coef_data(i_coef_data), .i_coef_valid(i_coef_valid), .o_coef_ready(o_coef_ready),
    .i_smp_data(i_smp_data), .i_smp_valid(i_smp_valid), .o_smp_ready(o_smp_ready),
    .o_cin(o_cin), .o_caddr(o_caddr), .o_cload(o_cload),
    .o_din(o_din), .o_valid_in(o_valid_in),
    .o_load_done(o_load_done), .o_load_timeout(o_load_timeout), .o_underrun(o_underrun)
  );

  always #5 clk_fast = ~clk_fast;

  int total = 0;
  int bad = 0;

  // Scenario knobs
  int coefProb, coefLimit, smpProb, smpStart, smpLimit;
  bit smpRandom;

  // Reference model state: cycle index since reset release, accepted
  // coefficients, last accept cycle, and the sample side as a one-deep queue.
  int          cyc, nAcc, lastAcc, smpIdx;
  logic [16:0] coefVals [NCOEF];
  logic [15:0] smpList [3];
  logic [15:0] smpCur, mBuf, mDin;
  logic        mBufFull, mValid, mUnderrun;

  function automatic bit mDone();
    return (cyc >= LOAD_WINDOW) || (nAcc == NCOEF && cyc >= lastAcc + 3);
  endfunction

  function automatic bit mTimeout();
    return (cyc >= LOAD_WINDOW) && !(nAcc == NCOEF && lastAcc + 3 <= LOAD_WINDOW);
  endfunction

  function automatic bit mCoefReady();
    return !mDone() && (lastAcc < 0 || cyc >= lastAcc + 3);
  endfunction

  function automatic bit mPhase0(input int c);
    return (c == FIRST_FRAME) || (c > FIRST_FRAME && (c - FIRST_FRAME) % FRAME_LEN == 0);
  endfunction

  // One comparison: counts, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_coef_ready", 32'(o_coef_ready), 32'd1);
    checkOutput("rst_smp_ready", 32'(o_smp_ready), 32'd0);
    checkOutput("rst_cin", 32'(o_cin), 32'd0);
    checkOutput("rst_caddr", 32'(o_caddr), 32'd0);
    checkOutput("rst_cload", 32'(o_cload), 32'd0);
    checkOutput("rst_din", 32'(o_din), 32'd0);
    checkOutput("rst_valid_in", 32'(o_valid_in), 32'd0);
    checkOutput("rst_load_done", 32'(o_load_done), 32'd0);
    checkOutput("rst_load_timeout", 32'(o_load_timeout), 32'd0);
    checkOutput("rst_underrun", 32'(o_underrun), 32'd0);
  endtask

  task automatic checkCycle();
    bit expCload;
    expCload = (lastAcc >= 0) && (cyc == lastAcc + 2) && (cyc < LOAD_WINDOW);
    checkOutput("coef_ready", 32'(o_coef_ready), 32'(mCoefReady()));
    checkOutput("cload", 32'(o_cload), 32'(expCload));
    if (expCload) begin
      checkOutput("caddr", 32'(o_caddr), 32'(nAcc - 1));
      checkOutput("cin", 32'(o_cin), 32'(coefVals[nAcc - 1]));
    end
    checkOutput("load_done", 32'(o_load_done), 32'(mDone()));
    checkOutput("load_timeout", 32'(o_load_timeout), 32'(mTimeout()));
    checkOutput("smp_ready", 32'(o_smp_ready), 32'(mDone() && !mBufFull));
    checkOutput("valid_in", 32'(o_valid_in), 32'(mValid));
    checkOutput("din", 32'(o_din), 32'(mDin));
    checkOutput("underrun", 32'(o_underrun), 32'(mUnderrun));
  endtask

  // Drive this cycle's upstream traffic and advance the model to the
  // state it predicts for the next cycle.
  task automatic applyStimulus();
    bit streaming, cv, sv, acc;
    logic [15:0] sd;
    streaming = mDone();
    cv = (nAcc < coefLimit) && ($urandom_range(99) < coefProb);
    i_coef_valid = cv;
    i_coef_data  = (nAcc < NCOEF) ? coefVals[nAcc] : 17'h0;
    if (cv && mCoefReady()) begin
      lastAcc = cyc;
      nAcc++;
    end
    sv = (cyc >= smpStart) && (smpIdx < smpLimit) && ($urandom_range(99) < smpProb);
    sd = smpRandom ? smpCur : smpList[smpIdx % 3];
    i_smp_valid = sv;
    i_smp_data  = sd;
    acc = sv && streaming && !mBufFull;
    mValid = mPhase0(cyc + 1);
    if (mValid) begin
      if (!streaming) begin
        mDin = 16'h0000;
      end else if (mBufFull) begin
        mDin = mBuf;
        mBufFull = 1'b0;
      end else begin
        mUnderrun = 1'b1;
`ifndef FEEDER_UNDERRUN_HOLD_EN
        mDin = 16'h0000;
`endif
        if (acc) begin
          mBuf = sd;
          mBufFull = 1'b1;
        end
      end
    end else if (acc) begin
      mBuf = sd;
      mBufFull = 1'b1;
    end
    if (acc) begin
      smpIdx++;
      smpCur = 16'($urandom);
    end
  endtask

  task automatic resetModel();
    cyc = 0; nAcc = 0; lastAcc = -1; smpIdx = 0;
    mBufFull = 1'b0; mBuf = '0; mDin = '0; mValid = 1'b0; mUnderrun = 1'b0;
    smpCur = 16'($urandom);
  endtask

  task automatic setupScenario(input bit cRandom, input int cProb, input int cLimit,
                               input bit sRandom, input int sProb, input int sStart,
                               input int sLimit);
    for (int k = 0; k < NCOEF; k++)
      coefVals[k] = cRandom ? 17'($urandom) : 17'(k + 1);
    coefProb = cProb; coefLimit = cLimit;
    smpRandom = sRandom; smpProb = sProb; smpStart = sStart; smpLimit = sLimit;
  endtask

  // Asynchronous reset from wherever the run currently is; reset values are
  // checked immediately, before any clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    i_coef_valid = 1'b0;
    i_smp_valid = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst_n = 1'b1;
    #1;
    resetModel();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      checkCycle();
      applyStimulus();
      @(negedge clk_fast);
      #1;
      cyc++;
    end
  endtask

  initial begin
    smpList[0] = 16'h3C00;
    smpList[1] = 16'h4000;
    smpList[2] = 16'h4200;
    #2;

    $display("[TB] full load 1..64 with valid held, three preloaded samples then starvation");
    setupScenario(1'b0, 100, NCOEF, 1'b0, 100, 0, 3);
    doReset();
    runCycles(1100);

    $display("[TB] backpressured random load, sparse random samples");
    setupScenario(1'b1, 75, NCOEF, 1'b1, 2, 0, 1000);
    doReset();
    runCycles(1400);

    $display("[TB] load timeout with 10 coefficients, sample accepted on the phase-0 edge");
    setupScenario(1'b1, 100, 10, 1'b1, 100, 255, 1000);
    doReset();
    runCycles(800);

    $display("[TB] reset mid-load at cycle 100, then full reload");
    setupScenario(1'b1, 100, NCOEF, 1'b1, 50, 0, 1000);
    doReset();
    runCycles(100);
    doReset();
    runCycles(1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
